fp_addsub_seq: RTL and testbench
================================

// Module: fp_addsub_seq
// PURPOSE
//  Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor (Y = A +/- B).
//  Generalises the single-precision adder_fp to any exponent/mantissa width.
//  Adds round-to-nearest-even, special-value handling and exception flags.
//  Fixed latency; sits behind a start/ready/busy handshake in the FP datapath.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W  23  stored fraction width (hidden bit implicit)
//  W      1+EXP_W+MAN_W (localparam) total operand width
// PORTS
//  clk    in   1   rising-edge clock
//  rst_n  in   1   synchronous reset, active low
//  start  in   1   request; sampled only while busy=0
//  op     in   1   0 = A+B, 1 = A-B; captured with start
//  A      in   W   operand A; captured with start
//  B      in   W   operand B; captured with start
//  Y      out  W   result; valid when ready=1, held until next result
//  ready  out  1   one-cycle pulse: Y/exc valid
//  busy   out  1   high from accept until ready pulse
//  exc    out  4   {invalid, overflow, underflow, inexact}; valid and held as Y
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
//  Reset: Y=0, exc=0, ready=0, busy=0, FSM=IDLE; aborts any op in flight, no ready pulse.
//  FSM: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE.
//   IDLE:   start=1 captures A, B, op; busy<=1.
//   ALIGN:  unpack; swap so |X|>=|Z|; shift smaller significand right by exp diff
//           (barrel shift, one cycle); OR shifted-out bits into sticky.
//           Diff >= MAN_W+3: significand becomes 0, sticky = any nonzero bit.
//   ADDSUB: effective sign = signA ^ signB ^ op; add or subtract significands
//           (MAN_W+4 bits: hidden, frac, G, R, S, plus carry).
//   NORM:   carry -> shift right 1 (sticky accumulates), exp+1.
//           Otherwise shift left by leading-zero count (priority encoder, one cycle).
//   ROUND:  RNE on G/R/S; mantissa-overflow renormalise. Register Y and exc;
//           ready<=1 for one cycle; busy<=0; return to IDLE.
//  Latency: start sampled at edge k -> ready=1 in the cycle after edge k+4.
//   Fixed for all operands, including special values.
//  Handshake:
//   - start while busy=1 is ignored, with no effect on the op in flight.
//   - start in the ready cycle is accepted (busy=0 there): back-to-back ops every 5 cycles.
//  Special values (decided in ALIGN, carried to ROUND):
//   - Any NaN input -> canonical qNaN: sign 0, exp all 1s, frac MSB 1, rest 0.
//   - inf - inf (effective) -> qNaN, invalid=1.
//   - inf op finite -> that inf with its effective sign.
//   - Subnormal inputs flushed to signed zero (FTZ); no flag raised.
//  Result rules:
//   - Exact-zero sum -> +0, except (-0)+(-0) and (-0)-(+0) -> -0.
//   - Rounded exp >= all-1s -> signed inf, overflow=1, inexact=1.
//   - Normalised exp <= 0 -> signed zero, underflow=1, inexact=1.
//   - inexact=1 whenever G|R|S != 0 before rounding.
// TESTING
//  1. 0x3F800000 + 0x40000000, op=0 -> Y=0x40400000, exc=0, ready 5 edges after start.
//  2. 0x3F800000 - 0x3F800000, op=1 -> Y=0x00000000, exc=0.
//     0x3F800000 + 0x33800000 -> Y=0x3F800000, inexact=1 (tie to even).
//  3. 0x7F7FFFFF + 0x7F7FFFFF -> Y=0x7F800000, exc=4'b0101.
//     0x7F800000 - 0x7F800000 -> Y=0x7FC00000, exc=4'b1000.
//  4. NaN 0x7F800001 + 0x3F800000 -> Y=0x7FC00000.
//     Subnormal 0x00000001 + 0x3F800000 -> Y=0x3F800000, exc=0.
//  5. start pulsed while busy -> ignored; first result unchanged.
//     start in the ready cycle -> second result 5 edges later.
//     rst_n=0 two cycles after start -> busy=0, Y=0, no ready pulse.
//  6. EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000.
//     0x7BFF + 0x7BFF -> 0x7C00, overflow=1.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle parametrised floating-point adder/subtractor.
// Fixed five-state sequence with RNE rounding, flush-to-zero inputs and exception flags.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Y,
  output logic         ready,
  output logic         busy,
  output logic [3:0]   exc
);

  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int EXE_W = EXP_W + 2;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND} state_t;
  state_t r_state, w_state_next;

  logic [W-1:0]     r_a, r_b;
  logic             r_op;
  logic             r_sign, r_sub, r_spec;
  logic [EXP_W-1:0] r_exp;
  logic [SIG_W-1:0] r_sig_x, r_sig_z;
  logic [W-1:0]     r_spec_y;
  logic [3:0]       r_spec_exc;
  logic [SUM_W-1:0] r_sum;
  logic [SIG_W-1:0] r_nsig;
  logic [EXE_W-1:0] r_nexp;
  logic             r_nzero;
  logic [W-1:0]     r_y;
  logic [3:0]       r_exc;
  logic             r_ready, r_busy;

  assign Y     = r_y;
  assign exc   = r_exc;
  assign ready = r_ready;
  assign busy  = r_busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_ALIGN;
      S_ALIGN:  w_state_next = S_ADDSUB;
      S_ADDSUB: w_state_next = S_NORM;
      S_NORM:   w_state_next = S_ROUND;
      S_ROUND:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ---------------- ALIGN: unpack, order by magnitude, align smaller operand
  logic             w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_swap, w_sx, w_sz, w_far, w_z_lost, w_spec;
  logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ez, w_diff;
  logic [W-2:0]     w_mag_a, w_mag_b, w_mx, w_mz;
  logic [SIG_W-1:0] w_sig_x, w_sig_z, w_z_shr, w_sig_z_al;
  logic [W-1:0]     w_spec_y;
  logic [3:0]       w_spec_exc;

  assign w_sa    = r_a[W-1];
  assign w_sb    = r_b[W-1] ^ r_op;
  assign w_ea    = r_a[W-2 -: EXP_W];
  assign w_eb    = r_b[W-2 -: EXP_W];
  assign w_a_nan = (w_ea == EXP_MAX) && (r_a[MAN_W-1:0] != '0);
  assign w_b_nan = (w_eb == EXP_MAX) && (r_b[MAN_W-1:0] != '0);
  assign w_a_inf = (w_ea == EXP_MAX) && (r_a[MAN_W-1:0] == '0);
  assign w_b_inf = (w_eb == EXP_MAX) && (r_b[MAN_W-1:0] == '0);
  assign w_spec  = w_a_nan | w_b_nan | w_a_inf | w_b_inf;

  // A zero exponent field (zero or subnormal) collapses to an all-zero magnitude.
  assign w_mag_a = (w_ea == '0) ? '0 : r_a[W-2:0];
  assign w_mag_b = (w_eb == '0) ? '0 : r_b[W-2:0];
  assign w_swap  = w_mag_b > w_mag_a;
  assign w_sx    = w_swap ? w_sb : w_sa;
  assign w_sz    = w_swap ? w_sa : w_sb;
  assign w_mx    = w_swap ? w_mag_b : w_mag_a;
  assign w_mz    = w_swap ? w_mag_a : w_mag_b;
  assign w_ex    = w_mx[W-2 -: EXP_W];
  assign w_ez    = w_mz[W-2 -: EXP_W];
  assign w_sig_x = {w_ex != '0, w_mx[MAN_W-1:0], 3'b000};
  assign w_sig_z = {w_ez != '0, w_mz[MAN_W-1:0], 3'b000};

  assign w_diff     = w_ex - w_ez;
  assign w_z_shr    = w_sig_z >> w_diff;
  assign w_z_lost   = (w_z_shr << w_diff) != w_sig_z;
  assign w_far      = {{(32-EXP_W){1'b0}}, w_diff} >= 32'(MAN_W + 3);
  assign w_sig_z_al = w_far ? {{(SIG_W-1){1'b0}}, |w_sig_z}
                            : {w_z_shr[SIG_W-1:1], w_z_shr[0] | w_z_lost};

  always_comb begin
    w_spec_y   = '0;
    w_spec_exc = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_y = QNAN;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_spec_y   = QNAN;
      w_spec_exc = 4'b1000;
    end else if (w_a_inf) begin
      w_spec_y = {w_sa, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      w_spec_y = {w_sb, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  // ---------------- NORM: carry right-shift or leading-zero left-shift
  logic [LZ_W-1:0]  w_lzc;
  logic [SIG_W-1:0] w_nsig;
  logic [EXE_W-1:0] w_nexp;

  always_comb begin
    w_lzc = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (r_sum[i]) w_lzc = LZ_W'(SIG_W - 1 - i);
    end
  end

  always_comb begin
    if (r_sum[SUM_W-1]) begin
      w_nsig = {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
      w_nexp = {2'b00, r_exp} + EXE_W'(1);
    end else begin
      w_nsig = r_sum[SIG_W-1:0] << w_lzc;
      w_nexp = {2'b00, r_exp} - {{(EXE_W-LZ_W){1'b0}}, w_lzc};
    end
  end

  // ---------------- ROUND: nearest-even on G/R/S, then range checks
  logic             w_inexact, w_rup, w_ovf, w_unf, w_zero_sign;
  logic [MAN_W+1:0] w_mant;
  logic [EXE_W-1:0] w_rexp;
  logic [MAN_W-1:0] w_rfrac;
  logic [W-1:0]     w_res_y;
  logic [3:0]       w_res_exc;

  assign w_inexact   = |r_nsig[2:0];
  assign w_rup       = r_nsig[2] & (r_nsig[1] | r_nsig[0] | r_nsig[3]);
  assign w_mant      = {1'b0, r_nsig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
  assign w_rexp      = r_nexp + {{(EXE_W-1){1'b0}}, w_mant[MAN_W+1]};
  assign w_rfrac     = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
  assign w_unf       = r_nexp[EXE_W-1] || (r_nexp == '0);
  assign w_ovf       = !w_rexp[EXE_W-1] && (w_rexp[EXE_W-2:0] >= {1'b0, EXP_MAX});
  // Cancellation gives +0; only two same-signed zeros keep their sign.
  assign w_zero_sign = r_sub ? 1'b0 : r_sign;

  always_comb begin
    w_res_y   = {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
    w_res_exc = {3'b000, w_inexact};
    if (r_spec) begin
      w_res_y   = r_spec_y;
      w_res_exc = r_spec_exc;
    end else if (r_nzero) begin
      w_res_y   = {w_zero_sign, {(W-1){1'b0}}};
      w_res_exc = 4'b0000;
    end else if (w_unf) begin
      w_res_y   = {r_sign, {(W-1){1'b0}}};
      w_res_exc = 4'b0011;
    end else if (w_ovf) begin
      w_res_y   = {r_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_res_exc = 4'b0101;
    end
  end

  // ---------------- registers
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_exc   <= 4'b0000;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE:  if (start) r_busy <= 1'b1;
        S_ROUND: begin
          r_y     <= w_res_y;
          r_exc   <= w_res_exc;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers are only consumed in the state after they are loaded.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (start) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= op;
      end
      S_ALIGN: begin
        r_sign     <= w_sx;
        r_sub      <= w_sx ^ w_sz;
        r_exp      <= w_ex;
        r_sig_x    <= w_sig_x;
        r_sig_z    <= w_sig_z_al;
        r_spec     <= w_spec;
        r_spec_y   <= w_spec_y;
        r_spec_exc <= w_spec_exc;
      end
      S_ADDSUB: r_sum <= r_sub ? ({1'b0, r_sig_x} - {1'b0, r_sig_z})
                               : ({1'b0, r_sig_x} + {1'b0, r_sig_z});
      S_NORM: begin
        r_nsig  <= w_nsig;
        r_nexp  <= w_nexp;
        r_nzero <= (r_sum == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed vectors for single and half precision instances.
// Driver queues expected results; per-instance monitors pop and compare on ready.
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst_n, start, op, ready, busy;
  logic [31:0] a, b, y;
  logic [3:0]  exc;
  logic        start_h, op_h, ready_h, busy_h;
  logic [15:0] a_h, b_h, y_h;
  logic [3:0]  exc_h;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  exc;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t qh[$];

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .Y(y), .ready(ready), .busy(busy), .exc(exc)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(start_h), .op(op_h), .A(a_h), .B(b_h),
    .Y(y_h), .ready(ready_h), .busy(busy_h), .exc(exc_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_ready: got ready with Y=%h, expected no result", y);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn sp %-14s Y=%h exc=%b cycle=%0d", e.name, y, exc, cyc);
        check({e.name, "_Y"}, y, e.y);
        check({e.name, "_exc"}, {28'd0, exc}, {28'd0, e.exc});
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ready_h === 1'b1) begin
      if (qh.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_ready_h: got ready with Y=%h, expected no result", y_h);
      end else begin
        exp_t e;
        e = qh.pop_front();
        $display("txn hp %-14s Y=%h exc=%b cycle=%0d", e.name, y_h, exc_h, cyc);
        check({e.name, "_Y"}, {16'd0, y_h}, e.y);
        check({e.name, "_exc"}, {28'd0, exc_h}, {28'd0, e.exc});
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the ready cycle so the
  // next call lands back-to-back.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       input logic [31:0] ey, input logic [3:0] eexc, input string nm);
    exp_t e;
    start = 1'b1; a = ia; b = ib; op = iop;
    e.y = ey; e.exc = eexc; e.cyc = cyc + 5; e.name = nm;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic issue_h(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                         input logic [15:0] ey, input logic [3:0] eexc, input string nm);
    exp_t e;
    start_h = 1'b1; a_h = ia; b_h = ib; op_h = iop;
    e.y = {16'd0, ey}; e.exc = eexc; e.cyc = cyc + 5; e.name = nm;
    qh.push_back(e);
    @(negedge clk);
    start_h = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    start_h = 1'b0; op_h = 1'b0; a_h = '0; b_h = '0;
    repeat (3) @(negedge clk);
    check("rst_Y", y, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_exc", {28'd0, exc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "one_plus_two");
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one");
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even_down");
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_minus_inf");
    issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "nan_in");
    issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, "subnormal_ftz");
    issue(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000, "two_minus_three");
    issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, "round_up_sticky");
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie_even_up");
    issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, "underflow");
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negz_plus_negz");
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, "negz_minus_posz");
    issue(32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000, "one_minus_neginf");
    issue(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, "carry_renorm");
    issue(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000, "neg_two_plus_one");

    // start while busy must neither restart nor corrupt the op in flight
    start = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = 1'b0;
    begin
      exp_t e;
      e.y = 32'h40400000; e.exc = 4'b0000; e.cyc = cyc + 5; e.name = "busy_ignore";
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'd1);
    start = 1'b1; a = 32'h40000000; b = 32'h40000000; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset two cycles into an op: abort, no result
    start = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_Y", y, 32'h0);
    check("abort_exc", {28'd0, exc}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (8) @(negedge clk);

    issue_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, "h_one_plus_one");
    issue_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, "h_overflow");
    issue_h(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000, "h_one_minus_one");
    issue_h(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001, "h_tie_even");
    issue_h(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0000, "h_nan_in");

    repeat (8) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    check("queue_h_empty", qh.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
